// File: rtl/neokeon_rotate_engine.sv
// Multi-cycle word-rotation engine: each word steps one bit position per clock
// until its own amount is consumed, then the result is held until acknowledged.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a request; latches data, amounts and direction
// ROTATE | every word with a nonzero remaining count rotates by one bit
// DONE   | result valid on outData, held until inAck
module neokeon_rotate_engine #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4,
    localparam int AW = $clog2(WIDTH)
) (
    input  logic                   inClk,
    input  logic                   inRst,
    input  logic                   inValid,
    output logic                   outReady,
    input  logic [WIDTH*WORDS-1:0] inData,
    input  logic [AW*WORDS-1:0]    inAmount,
    input  logic                   inDir,
    output logic                   outValid,
    input  logic                   inAck,
    output logic [WIDTH*WORDS-1:0] outData,
    output logic                   outBusy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } stateT;

    stateT                  state;
    logic [WIDTH*WORDS-1:0] workReg;
    logic [AW*WORDS-1:0]    remCnt;
    logic                   dirReg;

    logic [WIDTH*WORDS-1:0] rotNext;
    logic [AW*WORDS-1:0]    cntNext;

    // One-bit step for every word still owing rotations; exhausted words hold.
    always_comb begin
        rotNext = workReg;
        cntNext = remCnt;
        for (int i = 0; i < WORDS; i++) begin
            if (remCnt[i*AW +: AW] != '0) begin
                if (dirReg)
                    rotNext[i*WIDTH +: WIDTH] = {workReg[i*WIDTH], workReg[i*WIDTH+1 +: WIDTH-1]};
                else
                    rotNext[i*WIDTH +: WIDTH] = {workReg[i*WIDTH +: WIDTH-1], workReg[i*WIDTH+WIDTH-1]};
                cntNext[i*AW +: AW] = remCnt[i*AW +: AW] - AW'(1);
            end
        end
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            state    <= IDLE;
            workReg  <= '0;
            remCnt   <= '0;
            dirReg   <= 1'b0;
            outValid <= 1'b0;
            outBusy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        workReg <= inData;
                        remCnt  <= inAmount;
                        dirReg  <= inDir;
                        if (inAmount == '0) begin
                            state    <= DONE;
                            outValid <= 1'b1;
                        end else begin
                            state   <= ROTATE;
                            outBusy <= 1'b1;
                        end
                    end
                end
                ROTATE: begin
                    workReg <= rotNext;
                    remCnt  <= cntNext;
                    if (cntNext == '0) begin
                        state    <= DONE;
                        outBusy  <= 1'b0;
                        outValid <= 1'b1;
                    end
                end
                DONE: begin
                    if (inAck) begin
                        state    <= IDLE;
                        outValid <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    outValid <= 1'b0;
                    outBusy  <= 1'b0;
                end
            endcase
        end
    end

    assign outReady = (state == IDLE) && !inRst;
    assign outData  = workReg;

endmodule

// File: tb/tb_neokeon_rotate_engine.sv
// Self-checking bench for neokeon_rotate_engine (WIDTH=32, WORDS=4) against a
// whole-word rotate reference model.
module tb_neokeon_rotate_engine;

    localparam int WIDTH = 32;
    localparam int WORDS = 4;
    localparam int AW    = 5;

    logic                   inClk = 1'b0;
    logic                   inRst = 1'b0;
    logic                   inValid = 1'b0;
    logic                   outReady;
    logic [WIDTH*WORDS-1:0] inData = '0;
    logic [AW*WORDS-1:0]    inAmount = '0;
    logic                   inDir = 1'b0;
    logic                   outValid;
    logic                   inAck = 1'b0;
    logic [WIDTH*WORDS-1:0] outData;
    logic                   outBusy;

    int errors = 0;
    int checks = 0;

    neokeon_rotate_engine #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .inClk(inClk), .inRst(inRst), .inValid(inValid), .outReady(outReady),
        .inData(inData), .inAmount(inAmount), .inDir(inDir), .outValid(outValid),
        .inAck(inAck), .outData(outData), .outBusy(outBusy)
    );

    always #5 inClk = ~inClk;

    function automatic logic [31:0] rotWord(input logic [31:0] w, input int n, input logic dir);
        int l;
        l = dir ? (WIDTH - n) % WIDTH : n;
        if (l == 0) return w;
        return (w << l) | (w >> (WIDTH - l));
    endfunction

    function automatic logic [127:0] refModel(input logic [127:0] d, input logic [19:0] a, input logic dir);
        logic [127:0] r;
        for (int i = 0; i < WORDS; i++)
            r[i*WIDTH +: WIDTH] = rotWord(d[i*WIDTH +: WIDTH], int'(a[i*AW +: AW]), dir);
        return r;
    endfunction

    function automatic int maxAmount(input logic [19:0] a);
        int m = 0;
        for (int i = 0; i < WORDS; i++)
            if (int'(a[i*AW +: AW]) > m) m = int'(a[i*AW +: AW]);
        return m;
    endfunction

    task automatic tick();
        @(posedge inClk);
        #1;
    endtask

    // Issues one request and waits for outValid; reports latency (cycles from
    // the accept edge to the first outValid sample) and cycles outBusy was high.
    task automatic doTxn(input logic [127:0] d, input logic [19:0] a, input logic dir,
                         output int lat, output int busyCnt, output logic [127:0] res,
                         output bit timedOut);
        int guard = 0;
        timedOut = 1'b0;
        lat = 0;
        busyCnt = 0;
        while (!outReady && guard < 50) begin
            tick();
            guard++;
        end
        inData = d;
        inAmount = a;
        inDir = dir;
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        lat = 1;
        while (!outValid && lat < 100) begin
            if (outBusy) busyCnt++;
            tick();
            lat++;
        end
        if (!outValid) timedOut = 1'b1;
        res = outData;
    endtask

    task automatic doAck();
        inAck = 1'b1;
        tick();
        inAck = 1'b0;
    endtask

    task automatic test_reset();
        inRst = 1'b1;
        tick();
        tick();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", outValid); end
        checks++; if (outBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", outBusy); end
        checks++; if (outReady !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst got=%b want=0", outReady); end
        checks++; if (outData !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", outData); end
        inRst = 1'b0;
        #1;
        checks++; if (outReady !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b want=1", outReady); end
    endtask

    task automatic test_single();
        int lat, busy; logic [127:0] res; bit to;
        logic [127:0] d = {32'h01020304, 32'h55667788, 32'hcafef00d, 32'h1111aaaa};
        doTxn(d, 20'd1, 1'b0, lat, busy, res, to);
        checks++; if (to || lat != 2) begin errors++; $display("FAIL single_latency got=%0d want=2", lat); end
        checks++; if (res !== {d[127:32], 32'h22235554}) begin errors++; $display("FAIL single_data got=%h want=%h", res, {d[127:32], 32'h22235554}); end
        doAck();
    endtask

    task automatic test_amounts();
        int lat, busy; logic [127:0] res; bit to;
        doTxn({96'h0, 32'h1111aaaa}, 20'd8, 1'b0, lat, busy, res, to);
        checks++; if (to || lat != 9) begin errors++; $display("FAIL amt8_latency got=%0d want=9", lat); end
        checks++; if (res[31:0] !== 32'h11aaaa11) begin errors++; $display("FAIL amt8_data got=%h want=11aaaa11", res[31:0]); end
        doAck();
        doTxn({96'h0, 32'h1111aaaa}, 20'd1, 1'b1, lat, busy, res, to);
        checks++; if (res[31:0] !== 32'h0888d555 || to) begin errors++; $display("FAIL right1_data got=%h want=0888d555", res[31:0]); end
        doAck();
        doTxn({96'h0, 32'h1111aaaa}, 20'd31, 1'b0, lat, busy, res, to);
        checks++; if (res[31:0] !== 32'h0888d555 || to) begin errors++; $display("FAIL left31_data got=%h want=0888d555", res[31:0]); end
        checks++; if (lat != 32) begin errors++; $display("FAIL left31_latency got=%0d want=32", lat); end
        doAck();
    endtask

    task automatic test_pi1();
        int lat, busy; logic [127:0] res; bit to;
        logic [127:0] d = {32'h12345678, 32'hc0000000, 32'h80000001, 32'h00000000};
        logic [19:0] a = {5'd2, 5'd5, 5'd1, 5'd0};
        logic [127:0] want = {32'h48d159e0, 32'h00000018, 32'h00000003, 32'h00000000};
        doTxn(d, a, 1'b0, lat, busy, res, to);
        checks++; if (to || lat != 6) begin errors++; $display("FAIL pi1_latency got=%0d want=6", lat); end
        checks++; if (busy != 5) begin errors++; $display("FAIL pi1_busy got=%0d want=5", busy); end
        checks++; if (res !== want) begin errors++; $display("FAIL pi1_data got=%h want=%h", res, want); end
        doAck();
    endtask

    task automatic test_zero();
        int lat, busy; logic [127:0] res; bit to;
        logic [127:0] d = {4{32'hdeadbeef}};
        doTxn(d, 20'd0, 1'b0, lat, busy, res, to);
        checks++; if (to || lat != 1) begin errors++; $display("FAIL zero_latency got=%0d want=1", lat); end
        checks++; if (busy != 0 || outBusy !== 1'b0) begin errors++; $display("FAIL zero_busy got=%0d want=0", busy); end
        checks++; if (res !== d) begin errors++; $display("FAIL zero_data got=%h want=%h", res, d); end
        doAck();
    endtask

    task automatic test_hold();
        int lat, busy; logic [127:0] res; bit to;
        logic [127:0] d = {32'hffff0000, 32'h0f0f0f0f, 32'h13579bdf, 32'h2468ace0};
        logic [19:0] a = {5'd24, 5'd3, 5'd16, 5'd7};
        logic [127:0] want;
        int bad = 0;
        want = refModel(d, a, 1'b1);
        doTxn(d, a, 1'b1, lat, busy, res, to);
        for (int c = 0; c < 20; c++) begin
            inValid = $urandom_range(0, 1);
            inData = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (outData !== want || outValid !== 1'b1 || outReady !== 1'b0) bad++;
        end
        inValid = 1'b0;
        checks++; if (bad != 0 || to) begin errors++; $display("FAIL hold_stable got=%0d bad cycles want=0 (data=%h valid=%b ready=%b)", bad, outData, outValid, outReady); end
        doAck();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL hold_ack_valid got=%b want=0", outValid); end
        checks++; if (outReady !== 1'b1) begin errors++; $display("FAIL hold_ack_ready got=%b want=1", outReady); end
    endtask

    task automatic test_back_to_back();
        int lat, busy; logic [127:0] res; bit to;
        doTxn({96'h0, 32'h00000001}, 20'd2, 1'b0, lat, busy, res, to);
        inValid = 1'b1;
        inData = {4{32'h0000000f}};
        inAmount = 20'd0;
        inAck = 1'b1;
        checks++; if (outReady !== 1'b0) begin errors++; $display("FAIL b2b_ready_on_ack got=%b want=0", outReady); end
        tick();
        inAck = 1'b0;
        checks++; if (outValid !== 1'b0 || outReady !== 1'b1) begin errors++; $display("FAIL b2b_not_accepted valid=%b ready=%b want 0,1", outValid, outReady); end
        tick();
        inValid = 1'b0;
        checks++; if (outValid !== 1'b1 || outData !== {4{32'h0000000f}}) begin errors++; $display("FAIL b2b_second got=%h valid=%b want=%h", outData, outValid, {4{32'h0000000f}}); end
        doAck();
    endtask

    task automatic test_reset_mid();
        int lat, busy; logic [127:0] res; bit to;
        int guard = 0;
        while (!outReady && guard < 50) begin tick(); guard++; end
        inData = {96'h0, 32'h1111aaaa};
        inAmount = 20'd24;
        inDir = 1'b0;
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        repeat (5) tick();
        checks++; if (outBusy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b want=1", outBusy); end
        inRst = 1'b1;
        tick();
        checks++; if (outValid !== 1'b0 || outBusy !== 1'b0) begin errors++; $display("FAIL midrst_flags valid=%b busy=%b want 0,0", outValid, outBusy); end
        checks++; if (outData !== '0) begin errors++; $display("FAIL midrst_data got=%h want=0", outData); end
        inRst = 1'b0;
        #1;
        checks++; if (outReady !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", outReady); end
        doTxn({96'h0, 32'h1111aaaa}, 20'd24, 1'b0, lat, busy, res, to);
        checks++; if (to || lat != 25 || res[31:0] !== 32'haa1111aa) begin errors++; $display("FAIL midrst_fresh got=%h lat=%0d want=aa1111aa lat=25", res[31:0], lat); end
        doAck();
    endtask

    task automatic test_random();
        int lat, busy; logic [127:0] res; bit to;
        logic [127:0] d, want;
        logic [19:0] a;
        logic dir;
        int m;
        for (int t = 0; t < 40; t++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < WORDS; i++)
                a[i*AW +: AW] = (t % 5 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            dir = 1'($urandom_range(0, 1));
            want = refModel(d, a, dir);
            m = maxAmount(a);
            doTxn(d, a, dir, lat, busy, res, to);
            checks++; if (to || res !== want) begin errors++; $display("FAIL rand_data t=%0d got=%h want=%h", t, res, want); end
            checks++; if (lat != m + 1 || busy != m) begin errors++; $display("FAIL rand_timing t=%0d got lat=%0d busy=%0d want lat=%0d busy=%0d", t, lat, busy, m + 1, m); end
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) tick();
            doAck();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_amounts();
        test_pi1();
        test_zero();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
